instruction_decoder: RTL and testbench

//  Registered XM-23 instruction decoder between instruction fetch and execute.

---
 rtl/instruction_decoder.sv | 164 ++++++++++++++++
 tb/tb_instruction_decoder.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/instruction_decoder.sv
// Registered XM-23 instruction decoder: classifies a 16-bit word into an opcode index and operand fields.
// Optional macro IDEC_STRICT_EN: reserved bits (SWAP/SWPB/SXT Instr[6]) must be 0 or the word is illegal.
module instruction_decoder (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] Instr,
    input  logic        E,
    input  logic        FLTi,
    output logic [6:0]  OP,
    output logic [12:0] OFF,
    output logic [3:0]  C,
    output logic [2:0]  T,
    output logic [2:0]  F,
    output logic [2:0]  PR,
    output logic [3:0]  SA,
    output logic [4:0]  PSWb,
    output logic [2:0]  DST,
    output logic [2:0]  SRCCON,
    output logic        WB,
    output logic        RC,
    output logic [7:0]  ImByte,
    output logic        PRPO,
    output logic        DEC,
    output logic        INC,
    output logic        FLTo
);

    localparam logic [6:0] OP_NONE = 7'h7F;

    function automatic logic [12:0] sext10(input logic signed [9:0] v);
        logic signed [12:0] w;
        w = 13'(v);
        return w;
    endfunction

    function automatic logic [12:0] sext7(input logic signed [6:0] v);
        logic signed [12:0] w;
        w = 13'(v);
        return w;
    endfunction

    logic [6:0]  op_p0;
    logic [12:0] off_p0;
    logic [3:0]  c_p0, sa_p0;
    logic [2:0]  t_p0, f_p0, pr_p0, dst_p0, srccon_p0;
    logic [4:0]  pswb_p0;
    logic [7:0]  imbyte_p0;
    logic        wb_p0, rc_p0, prpo_p0, dec_p0, inc_p0;
    logic        illegal_p0, flt_p0;
    logic        rsv_bad;

`ifdef IDEC_STRICT_EN
    assign rsv_bad = Instr[6];
`else
    assign rsv_bad = 1'b0;
`endif

    always_comb begin
        op_p0 = OP_NONE; off_p0 = '0; c_p0 = '0; t_p0 = '0; f_p0 = '0;
        pr_p0 = '0; sa_p0 = '0; pswb_p0 = '0; dst_p0 = '0; srccon_p0 = '0;
        wb_p0 = 1'b0; rc_p0 = 1'b0; imbyte_p0 = '0;
        prpo_p0 = 1'b0; dec_p0 = 1'b0; inc_p0 = 1'b0;
        illegal_p0 = 1'b0;
        case (Instr[15:13])
            3'b000: begin
                op_p0  = 7'd0;
                off_p0 = Instr[12:0];
            end
            3'b001: begin
                op_p0  = 7'd1 + {4'd0, Instr[12:10]};
                off_p0 = sext10(Instr[9:0]);
            end
            3'b010: begin
                if (!Instr[12]) begin
                    if (Instr[11:8] < 4'd12) begin
                        op_p0 = 7'd9 + {3'd0, Instr[11:8]};
                        rc_p0 = Instr[7]; wb_p0 = Instr[6];
                        srccon_p0 = Instr[5:3]; dst_p0 = Instr[2:0];
                    end else if (Instr[11:8] == 4'd12) begin
                        if (!Instr[7]) begin
                            op_p0 = 7'd21; wb_p0 = Instr[6];
                            srccon_p0 = Instr[5:3]; dst_p0 = Instr[2:0];
                        end else if (!Instr[6] && !rsv_bad) begin
                            op_p0 = 7'd22;
                            srccon_p0 = Instr[5:3]; dst_p0 = Instr[2:0];
                        end else begin
                            illegal_p0 = 1'b1;
                        end
                    end else if (Instr[11:8] == 4'd13) begin
                        // Single-operand and PSW-control group share the 0100 1101 prefix
                        if (!Instr[7]) begin
                            case (Instr[5:3])
                                3'b000: begin op_p0 = 7'd23; wb_p0 = Instr[6]; dst_p0 = Instr[2:0]; end
                                3'b001: begin op_p0 = 7'd24; wb_p0 = Instr[6]; dst_p0 = Instr[2:0]; end
                                3'b011: begin op_p0 = 7'd25; dst_p0 = Instr[2:0]; illegal_p0 = rsv_bad; end
                                3'b100: begin op_p0 = 7'd26; dst_p0 = Instr[2:0]; illegal_p0 = rsv_bad; end
                                default: illegal_p0 = 1'b1;
                            endcase
                        end else if (Instr[7:3] == 5'b10000) begin
                            op_p0 = 7'd27; pr_p0 = Instr[2:0];
                        end else if (Instr[7:4] == 4'b1001) begin
                            op_p0 = 7'd28; sa_p0 = Instr[3:0];
                        end else if (Instr[7:5] == 3'b101) begin
                            op_p0 = 7'd29; pswb_p0 = Instr[4:0];
                        end else if (Instr[7:5] == 3'b110) begin
                            op_p0 = 7'd30; pswb_p0 = Instr[4:0];
                        end else begin
                            illegal_p0 = 1'b1;
                        end
                    end else begin
                        illegal_p0 = 1'b1;
                    end
                end else begin
                    case (Instr[11:10])
                        2'b00: begin
                            op_p0 = 7'd31;
                            c_p0 = Instr[9:6]; t_p0 = Instr[5:3]; f_p0 = Instr[2:0];
                        end
                        2'b01: illegal_p0 = 1'b1;
                        default: begin
                            op_p0 = Instr[10] ? 7'd33 : 7'd32;
                            prpo_p0 = Instr[9]; dec_p0 = Instr[8]; inc_p0 = Instr[7];
                            wb_p0 = Instr[6]; srccon_p0 = Instr[5:3]; dst_p0 = Instr[2:0];
                        end
                    endcase
                end
            end
            3'b011: begin
                op_p0 = 7'd34 + {5'd0, Instr[12:11]};
                imbyte_p0 = Instr[10:3]; dst_p0 = Instr[2:0];
            end
            default: begin
                op_p0  = Instr[14] ? 7'd39 : 7'd38;
                off_p0 = sext7(Instr[13:7]);
                wb_p0 = Instr[6]; srccon_p0 = Instr[5:3]; dst_p0 = Instr[2:0];
            end
        endcase

        // Fault wins over any partial decode: only OP and FLTo carry information
        flt_p0 = illegal_p0 | FLTi;
        if (flt_p0) begin
            op_p0 = OP_NONE; off_p0 = '0; c_p0 = '0; t_p0 = '0; f_p0 = '0;
            pr_p0 = '0; sa_p0 = '0; pswb_p0 = '0; dst_p0 = '0; srccon_p0 = '0;
            wb_p0 = 1'b0; rc_p0 = 1'b0; imbyte_p0 = '0;
            prpo_p0 = 1'b0; dec_p0 = 1'b0; inc_p0 = 1'b0;
        end
    end

    // Stage p0 -> registered outputs
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            OP <= OP_NONE; OFF <= '0; C <= '0; T <= '0; F <= '0;
            PR <= '0; SA <= '0; PSWb <= '0; DST <= '0; SRCCON <= '0;
            WB <= 1'b0; RC <= 1'b0; ImByte <= '0;
            PRPO <= 1'b0; DEC <= 1'b0; INC <= 1'b0; FLTo <= 1'b0;
        end else if (E) begin
            OP <= op_p0; OFF <= off_p0; C <= c_p0; T <= t_p0; F <= f_p0;
            PR <= pr_p0; SA <= sa_p0; PSWb <= pswb_p0; DST <= dst_p0; SRCCON <= srccon_p0;
            WB <= wb_p0; RC <= rc_p0; ImByte <= imbyte_p0;
            PRPO <= prpo_p0; DEC <= dec_p0; INC <= inc_p0; FLTo <= flt_p0;
        end
    end

endmodule

// File: tb/tb_instruction_decoder.sv
// Directed bench for instruction_decoder: hand-computed vectors checked with immediate assertions.
module tb_instruction_decoder;

    logic        Clock = 1'b0;
    logic        Reset, E, FLTi;
    logic [15:0] Instr;
    logic [6:0]  OP;
    logic [12:0] OFF;
    logic [3:0]  C, SA;
    logic [2:0]  T, F, PR, DST, SRCCON;
    logic [4:0]  PSWb;
    logic [7:0]  ImByte;
    logic        WB, RC, PRPO, DEC, INC, FLTo;

    int total = 0;
    int passed = 0;

    instruction_decoder dut (
        .Clock(Clock), .Reset(Reset), .Instr(Instr), .E(E), .FLTi(FLTi),
        .OP(OP), .OFF(OFF), .C(C), .T(T), .F(F), .PR(PR), .SA(SA), .PSWb(PSWb),
        .DST(DST), .SRCCON(SRCCON), .WB(WB), .RC(RC), .ImByte(ImByte),
        .PRPO(PRPO), .DEC(DEC), .INC(INC), .FLTo(FLTo)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step(input logic [15:0] i, input logic e, input logic fi);
        @(negedge Clock);
        Instr = i; E = e; FLTi = fi;
        @(posedge Clock);
        #1;
    endtask

    initial begin
        Reset = 1'b1; E = 1'b0; FLTi = 1'b0; Instr = 16'h0000;
        #12;
        chk("rst_op", 32'(OP), 32'h7F);
        chk("rst_flt", 32'(FLTo), 32'h0);
        chk("rst_off", 32'(OFF), 32'h0);
        @(negedge Clock); Reset = 1'b0;

        step(16'h400A, 1'b1, 1'b0);
        chk("add_op", 32'(OP), 32'd9);
        chk("add_rc_wb", 32'({RC, WB}), 32'h0);
        chk("add_src", 32'(SRCCON), 32'd1);
        chk("add_dst", 32'(DST), 32'd2);
        chk("add_flt", 32'(FLTo), 32'h0);

        step(16'h1FFF, 1'b1, 1'b0);
        chk("bl_op", 32'(OP), 32'd0);
        chk("bl_off", 32'(OFF), 32'h1FFF);
        chk("bl_dst_zero", 32'(DST), 32'd0);

        step(16'h27FF, 1'b1, 1'b0);
        chk("bne_op", 32'(OP), 32'd2);
        chk("bne_off", 32'(OFF), 32'h1FFF);

        step(16'h3C00, 1'b1, 1'b0);
        chk("bra_op", 32'(OP), 32'd8);
        chk("bra_off", 32'(OFF), 32'h0);

        step(16'h652B, 1'b1, 1'b0);
        chk("movl_op", 32'(OP), 32'd34);
        chk("movl_imb", 32'(ImByte), 32'hA5);
        chk("movl_dst", 32'(DST), 32'd3);

        step(16'h5A93, 1'b1, 1'b0);
        chk("ld_op", 32'(OP), 32'd32);
        chk("ld_ppdi", 32'({PRPO, DEC, INC}), 32'b101);
        chk("ld_src", 32'(SRCCON), 32'd2);
        chk("ld_dst", 32'(DST), 32'd3);

        step(16'hA06E, 1'b1, 1'b0);
        chk("ldr_op", 32'(OP), 32'd38);
        chk("ldr_off", 32'(OFF), 32'h1FC0);
        chk("ldr_wb", 32'(WB), 32'd1);
        chk("ldr_src_dst", 32'({SRCCON, DST}), 32'({3'd5, 3'd6}));

        step(16'hDF80, 1'b1, 1'b0);
        chk("str_op", 32'(OP), 32'd39);
        chk("str_off", 32'(OFF), 32'h003F);

        step(16'h52AA, 1'b1, 1'b0);
        chk("cex_op", 32'(OP), 32'd31);
        chk("cex_ctf", 32'({C, T, F}), 32'({4'hA, 3'd5, 3'd2}));

        step(16'h4DB5, 1'b1, 1'b0);
        chk("setcc_op", 32'(OP), 32'd29);
        chk("setcc_psw", 32'(PSWb), 32'h15);

        step(16'h4D9C, 1'b1, 1'b0);
        chk("svc_op", 32'(OP), 32'd28);
        chk("svc_sa", 32'(SA), 32'hC);

        step(16'h4D63, 1'b1, 1'b0);
        chk("sxt_op", 32'(OP), 32'd26);
        chk("sxt_dst_wb", 32'({DST, WB}), 32'({3'd3, 1'b0}));

        step(16'h4DE0, 1'b1, 1'b0);
        chk("cc111_op", 32'(OP), 32'h7F);
        chk("cc111_flt", 32'(FLTo), 32'd1);

        step(16'h4E00, 1'b1, 1'b0);
        chk("ill_op", 32'(OP), 32'h7F);
        chk("ill_flt", 32'(FLTo), 32'd1);
        step(16'h400A, 1'b0, 1'b0);
        chk("hold_op", 32'(OP), 32'h7F);
        chk("hold_flt", 32'(FLTo), 32'd1);

        step(16'h400A, 1'b1, 1'b1);
        chk("flti_op", 32'(OP), 32'h7F);
        chk("flti_flt", 32'(FLTo), 32'd1);
        chk("flti_dst", 32'(DST), 32'd0);
        step(16'h400A, 1'b1, 1'b0);
        chk("post_flti_op", 32'(OP), 32'd9);
        chk("post_flti_flt", 32'(FLTo), 32'd0);

        // Asynchronous reset away from the clock edge
        @(negedge Clock);
        #2 Reset = 1'b1;
        #1;
        chk("async_rst_op", 32'(OP), 32'h7F);
        chk("async_rst_dst", 32'({SRCCON, DST}), 32'h0);
        chk("async_rst_flt", 32'(FLTo), 32'd0);
        step(16'h400A, 1'b1, 1'b0);
        chk("rst_hold_e1", 32'(OP), 32'h7F);
        step(16'h4E00, 1'b0, 1'b0);
        chk("rst_hold_e0", 32'(FLTo), 32'd0);
        @(negedge Clock); Reset = 1'b0;
        step(16'h652B, 1'b1, 1'b0);
        chk("after_rst_op", 32'(OP), 32'd34);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
